piso_tx: RTL and testbench

Parallel-in serial-out transmitter: accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock on a single serial line. It is the transmit side of the serial shift-register links in this design. With the default LSB-first order, a downstream chain of flip-flops that shifts toward bit 0 holds the original word once WIDTH bits have been clocked in. Back-to-back words stream without idle gaps.

---
 rtl/piso_tx.sv | 136 +++++++++++++
 tb/tb_piso_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
//
// A WIDTH-bit word is taken in through a valid/ready load handshake and then
// sent out one bit per clock on `out`. Each word gives WIDTH consecutive
// out_valid cycles, and `last` marks the final bit. A new word can be
// accepted on the same edge that retires the last bit of the current word,
// so words held back to back stream with no idle cycle in between.
//
// Handshake (load side): a word transfers on a rising edge of Clk where
// load_valid && load_ready are both high. load_ready is combinational from
// registered state and rst only, never from load_valid. A producer that
// raises load_valid must hold load_valid and din steady until that edge.
// load_valid seen while load_ready is low is ignored, and din is not sampled.
//
// Bit order: MSB_FIRST=0 sends din[0] first. With that order, a downstream
// chain that shifts toward bit 0 holds the original word once WIDTH bits
// have been clocked in. MSB_FIRST=1 sends din[WIDTH-1] first.
//
// FSM: two states. IDLE means no payload on out. SHIFT means out carries a
// payload bit. out_valid is a direct decode of the state register.

module piso_tx #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             last
);

    // Width of the bit counter. WIDTH is at least 2, so this is at least 1.
    localparam int CW = $clog2(WIDTH);

    // Counter value at which the next edge presents the final bit.
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 2);

    // FSM state encoding.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Registered state and its next-state values.
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_q,    sh_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             out_q,   out_d;
    logic             last_q,  last_d;

    // Helper nets for the shift path.
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] sh_adv;

    // out_valid is the state itself, so it is registered with no extra logic.
    assign out_valid = (state_q == ST_SHIFT);
    assign out       = out_q;
    assign last      = last_q;

    // The block can take a new word when idle, or when the bit on out now is
    // the last one of the current word. rst forces it low.
    assign load_ready = !rst && (!out_valid || last_q);

    // A word transfers on any edge where both sides agree.
    assign accept = load_valid && load_ready;

    // Select the bit-order dependent values: the first bit of a fresh word,
    // the bit that follows the current one, and the shift register after
    // moving one position toward the output end.
    always_comb begin
        if (MSB_FIRST != 0) begin
            first_bit = din[WIDTH-1];
            next_bit  = sh_q[WIDTH-2];
            sh_adv    = {sh_q[WIDTH-2:0], 1'b0};
        end else begin
            first_bit = din[0];
            next_bit  = sh_q[1];
            sh_adv    = {1'b0, sh_q[WIDTH-1:1]};
        end
    end

    // Next-state logic: load on accept, otherwise advance one bit or retire.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        last_d  = last_q;

        if (accept) begin
            // Fresh word. This covers an accept from IDLE and an accept on the
            // final bit of the previous word, which keeps streams gap-free.
            state_d = ST_SHIFT;
            sh_d    = din;
            cnt_d   = '0;
            out_d   = first_bit;
            last_d  = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            if (last_q) begin
                // Final bit has been shown and nothing follows: go quiet.
                state_d = ST_IDLE;
                out_d   = 1'b0;
                last_d  = 1'b0;
            end else begin
                // Present the next bit. cnt counts bits already shown, minus
                // one, so when it reaches WIDTH-2 the next bit is the last one.
                sh_d   = sh_adv;
                cnt_d  = cnt_q + CW'(1);
                out_d  = next_bit;
                last_d = (cnt_q == CNT_LAST);
            end
        end
    end

    // State registers. An asynchronous reset discards any word in flight.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx. Two instances, WIDTH=4, share the clock, the reset and
// the load stimulus: one sends LSB first and the other sends MSB first.
// Expected values come from the serial-link rules: bit i of a word is din[i]
// (LSB first) or din[3-i] (MSB first), and a word takes 4 cycles. Inputs are
// driven and outputs sampled 1 time unit after each rising edge.

module tb_piso_tx;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         load_valid;

    logic out_l, out_valid_l, last_l, ready_l;
    logic out_m, out_valid_m, last_m, ready_m;

    int pass_cnt;
    int total_cnt;

    piso_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .Clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (ready_l),
        .out        (out_l),
        .out_valid  (out_valid_l),
        .last       (last_l)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .Clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (ready_m),
        .out        (out_m),
        .out_valid  (out_valid_m),
        .last       (last_m)
    );

    // ---------------- clock and reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to the next sample point, 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit i (0 = first sent) of word w for the chosen bit order.
    function automatic logic bit_at(input logic [W-1:0] w, input int i, input bit msb);
        logic [W-1:0] t;
        t = w;
        return msb ? t[W-1-i] : t[i];
    endfunction

    // ---------------- tests ----------------

    // Reset from power-up, then an asynchronous reset in the middle of a word.
    task automatic test_reset();
        logic [3:0] obs_l, obs_m;
        rst = 1'b1;
        din = '0;
        load_valid = 1'b0;
        repeat (2) step();
        obs_l = {out_valid_l, last_l, ready_l, out_l};
        obs_m = {out_valid_m, last_m, ready_m, out_m};
        total_cnt++;
        if ({obs_l, obs_m} !== 8'h00)
            $display("FAIL reset_hold: got %b/%b want 0000/0000 (valid,last,ready,out)", obs_l, obs_m);
        else pass_cnt++;

        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if ({ready_l, ready_m, out_valid_l, out_valid_m} !== 4'b1100)
            $display("FAIL reset_release: ready/valid got %b want 1100",
                     {ready_l, ready_m, out_valid_l, out_valid_m});
        else pass_cnt++;
        step();

        // Start 4'hF, then hit reset mid-cycle during the second bit.
        din = 4'hF;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        step();
        #3 rst = 1'b1;
        #1;
        obs_l = {out_valid_l, last_l, ready_l, out_l};
        obs_m = {out_valid_m, last_m, ready_m, out_m};
        total_cnt++;
        if ({obs_l, obs_m} !== 8'h00)
            $display("FAIL reset_async_mid_word: got %b/%b want 0000/0000", obs_l, obs_m);
        else pass_cnt++;

        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        total_cnt++;
        if ({ready_l, ready_m, out_valid_l, out_valid_m, out_l, out_m} !== 6'b110000)
            $display("FAIL reset_mid_release: ready,valid,out got %b want 110000",
                     {ready_l, ready_m, out_valid_l, out_valid_m, out_l, out_m});
        else pass_cnt++;

        // Nothing from the aborted word may come back.
        step();
        total_cnt++;
        if ({out_valid_l, out_valid_m, out_l, out_m} !== 4'b0000)
            $display("FAIL reset_no_resume: valid,out got %b want 0000",
                     {out_valid_l, out_valid_m, out_l, out_m});
        else pass_cnt++;
    endtask

    // A single word sent from IDLE, followed by a return to IDLE.
    task automatic test_single(input logic [W-1:0] w);
        logic [3:0] exp_l, exp_m;
        din = w;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        din = ~w;
        for (int i = 0; i < W; i++) begin
            exp_l = {1'b1, i == W-1, i == W-1, bit_at(w, i, 1'b0)};
            exp_m = {1'b1, i == W-1, i == W-1, bit_at(w, i, 1'b1)};
            total_cnt++;
            if ({out_valid_l, last_l, ready_l, out_l} !== exp_l)
                $display("FAIL single_lsb w=%h bit%0d: got %b want %b", w, i,
                         {out_valid_l, last_l, ready_l, out_l}, exp_l);
            else pass_cnt++;
            total_cnt++;
            if ({out_valid_m, last_m, ready_m, out_m} !== exp_m)
                $display("FAIL single_msb w=%h bit%0d: got %b want %b", w, i,
                         {out_valid_m, last_m, ready_m, out_m}, exp_m);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if ({out_valid_l, last_l, ready_l, out_l, out_valid_m, last_m, ready_m, out_m} !== 8'b0010_0010)
            $display("FAIL single_idle w=%h: got %b want 00100010", w,
                     {out_valid_l, last_l, ready_l, out_l, out_valid_m, last_m, ready_m, out_m});
        else pass_cnt++;
        step();
    endtask

    // Two words with load_valid held high: 8 contiguous bits, no bubble.
    task automatic test_back_to_back();
        logic [W-1:0] words [2];
        logic [3:0] exp_l, exp_m;
        int k;
        words[0] = 4'hA;
        words[1] = 4'h5;
        total_cnt++;
        if ({ready_l, ready_m, out_valid_l, out_valid_m} !== 4'b1100)
            $display("FAIL b2b_cycle0: ready,valid got %b want 1100",
                     {ready_l, ready_m, out_valid_l, out_valid_m});
        else pass_cnt++;
        din = words[0];
        load_valid = 1'b1;
        step();
        din = words[1];
        for (int c = 1; c <= 2*W; c++) begin
            k = (c - 1) % W;
            exp_l = {1'b1, k == W-1, k == W-1, bit_at(words[(c-1)/W], k, 1'b0)};
            exp_m = {1'b1, k == W-1, k == W-1, bit_at(words[(c-1)/W], k, 1'b1)};
            total_cnt++;
            if ({out_valid_l, last_l, ready_l, out_l} !== exp_l)
                $display("FAIL b2b_lsb cycle%0d: got %b want %b", c,
                         {out_valid_l, last_l, ready_l, out_l}, exp_l);
            else pass_cnt++;
            total_cnt++;
            if ({out_valid_m, last_m, ready_m, out_m} !== exp_m)
                $display("FAIL b2b_msb cycle%0d: got %b want %b", c,
                         {out_valid_m, last_m, ready_m, out_m}, exp_m);
            else pass_cnt++;
            // The second word transfers on the edge after cycle 4.
            if (c == W + 1) load_valid = 1'b0;
            step();
        end
        total_cnt++;
        if ({out_valid_l, out_valid_m, ready_l, ready_m} !== 4'b0011)
            $display("FAIL b2b_idle: valid,ready got %b want 0011",
                     {out_valid_l, out_valid_m, ready_l, ready_m});
        else pass_cnt++;
        step();
    endtask

    // A one-cycle load offer of 4'h0 while 4'hF is busy must be ignored.
    task automatic test_busy_ignore();
        logic [3:0] exp;
        din = 4'hF;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == 1) begin
                din = 4'h0;
                load_valid = 1'b1;
            end else begin
                load_valid = 1'b0;
            end
            exp = {1'b1, i == W-1, i == W-1, 1'b1};
            total_cnt++;
            if ({out_valid_l, last_l, ready_l, out_l, out_valid_m, last_m, ready_m, out_m} !== {exp, exp})
                $display("FAIL busy_ignore bit%0d: got %b want %b", i,
                         {out_valid_l, last_l, ready_l, out_l, out_valid_m, last_m, ready_m, out_m},
                         {exp, exp});
            else pass_cnt++;
            step();
        end
        load_valid = 1'b0;
        total_cnt++;
        if ({out_valid_l, out_valid_m, out_l, out_m, ready_l, ready_m} !== 6'b000011)
            $display("FAIL busy_ignore_idle: valid,out,ready got %b want 000011",
                     {out_valid_l, out_valid_m, out_l, out_m, ready_l, ready_m});
        else pass_cnt++;
        step();
    endtask

    // Random words with random gaps, received by a shift chain per instance.
    // The model tracks how many bits of the current word remain; the word
    // queue holds words accepted but not yet fully received.
    task automatic test_loopback(input int n_words);
        logic [W-1:0] exp_q[$];
        logic [W-1:0] chain_l, chain_m, pend, w_exp;
        bit  have_pend;
        int  rem, rem_next, sent, done, cycles;
        bit  model_ready;
        int  errs_before;
        chain_l = '0;
        chain_m = '0;
        have_pend = 1'b0;
        pend = '0;
        rem = 0;
        sent = 0;
        done = 0;
        cycles = 0;
        errs_before = total_cnt - pass_cnt;
        while (done < n_words && cycles < 30000) begin
            model_ready = (rem <= 1);
            total_cnt++;
            if ({ready_l, ready_m, out_valid_l, out_valid_m, last_l, last_m} !==
                {model_ready, model_ready, rem > 0, rem > 0, rem == 1, rem == 1})
                $display("FAIL loop_ctrl cycle%0d: ready,valid,last got %b want %b", cycles,
                         {ready_l, ready_m, out_valid_l, out_valid_m, last_l, last_m},
                         {model_ready, model_ready, rem > 0, rem > 0, rem == 1, rem == 1});
            else pass_cnt++;

            if (rem > 0) begin
                chain_l = {out_l, chain_l[W-1:1]};
                chain_m = {chain_m[W-2:0], out_m};
                if (rem == 1) begin
                    w_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    total_cnt++;
                    if (chain_l !== w_exp || chain_m !== w_exp)
                        $display("FAIL loop_word %0d: chains lsb=%h msb=%h want %h",
                                 done, chain_l, chain_m, w_exp);
                    else pass_cnt++;
                    done++;
                end
            end

            // Producer: offer a new word after a random gap, hold it until taken.
            if (!have_pend && sent < n_words && $urandom_range(0, 2) != 0) begin
                pend = W'($urandom_range(0, (1 << W) - 1));
                have_pend = 1'b1;
            end
            load_valid = have_pend;
            din = have_pend ? pend : W'($urandom_range(0, (1 << W) - 1));

            if (have_pend && model_ready) begin
                exp_q.push_back(pend);
                have_pend = 1'b0;
                sent++;
                rem_next = W;
            end else begin
                rem_next = (rem > 0) ? rem - 1 : 0;
            end
            step();
            rem = rem_next;
            cycles++;
        end
        load_valid = 1'b0;
        total_cnt++;
        if (done !== n_words)
            $display("FAIL loop_timeout: words received %0d want %0d", done, n_words);
        else pass_cnt++;
        if (total_cnt - pass_cnt > errs_before)
            $display("loopback: %0d new failures", total_cnt - pass_cnt - errs_before);
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_single(4'b1011);
        test_single(4'b0110);
        test_back_to_back();
        test_busy_ignore();
        test_loopback(1000);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
